// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU built around a two-state sequencer (IDLE/RUN).
// One operation runs at a time. Single-cycle ops (ADD, SUB, CEQ, CLT, BR)
// spend one RUN cycle. Shifts spend one RUN cycle per bit shifted. MUL is a
// W-cycle unsigned shift-add.
//
// Ports
//   CLK            clock, rising edge
//   RESET          synchronous, active-high
//   START          operation request, sampled only while BUSY=0
//   OP[2:0]        000 ADD, 001 SUB, 010 CEQ, 011 CLT, 100 SHL, 101 SHR,
//                  110 MUL, 111 BR
//   INPUTA[W-1:0]  operand A, latched on acceptance
//   INPUTB[W-1:0]  operand B / shift count, latched on acceptance
//   BUSY           high while an accepted operation executes
//   DONE           one-cycle pulse, result valid
//   OUT[W-1:0]     result register, held between completions
//   FLAG_OUT       persistent compare flag
//   OVERFLOW_OUT   persistent carry / borrow / shift-out bit
//   FLAG_BRANCH_EN branch-taken pulse, only ever high together with DONE
module mc_alu #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic [2:0]   OP,
  input  logic [W-1:0] INPUTA,
  input  logic [W-1:0] INPUTB,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] OUT,
  output logic         FLAG_OUT,
  output logic         OVERFLOW_OUT,
  output logic         FLAG_BRANCH_EN
);

  localparam int CW = $clog2(W) + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_CEQ = 3'b010;
  localparam logic [2:0] OP_CLT = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_BR  = 3'b111;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  // Latched operation context. These are data registers and carry no reset.
  logic [2:0]      op_r;
  logic [W-1:0]    a_r;       // operand A; also the shift accumulator
  logic [W-1:0]    b_r;       // operand B; also the MUL multiplier (shifted right)
  logic            n_zero_r;  // shift count is zero: pass A straight through
  logic [2*W-1:0]  prod_r;
  logic [2*W-1:0]  mcand_r;

  logic [W:0]      sum_w;
  logic [W:0]      diff_w;
  logic [W-1:0]    shl_nxt;
  logic [W-1:0]    shr_nxt;
  logic [2*W-1:0]  mul_nxt;
  logic            last_run;
  logic            accept;

  // Shift count is B mod W, truncated to the counter width.
  function automatic logic [CW-1:0] shift_count(input logic [W-1:0] b);
    logic [31:0] m;
    m = 32'(b) % 32'(W);
    return CW'(m);
  endfunction

  // Number of RUN cycles for an operation.
  function automatic logic [CW-1:0] load_count(input logic [2:0] op,
                                               input logic [CW-1:0] n);
    logic [CW-1:0] c;
    c = CW'(1);
    if (op == OP_MUL)
      c = CW'(W);
    else if ((op == OP_SHL || op == OP_SHR) && n != '0)
      c = n;
    return c;
  endfunction

  assign accept   = (state == IDLE) && START;
  assign last_run = (cnt == CW'(1));

  always_comb begin
    // Carry / borrow come in from the persistent OVERFLOW register. A borrow
    // shows up as bit W of the W+1-bit difference because |A-B-ovf| <= 2^W.
    sum_w   = {1'b0, a_r} + {1'b0, b_r} + {{W{1'b0}}, OVERFLOW_OUT};
    diff_w  = {1'b0, a_r} - {1'b0, b_r} - {{W{1'b0}}, OVERFLOW_OUT};
    shl_nxt = {a_r[W-2:0], 1'b0};
    shr_nxt = {1'b0, a_r[W-1:1]};
    mul_nxt = prod_r + (b_r[0] ? mcand_r : {(2*W){1'b0}});
  end

  // ---- operand latch / iterative datapath ----
  always_ff @(posedge CLK) begin
    if (state == IDLE) begin
      if (START) begin
        op_r     <= OP;
        a_r      <= INPUTA;
        b_r      <= INPUTB;
        n_zero_r <= (shift_count(INPUTB) == '0);
        prod_r   <= '0;
        mcand_r  <= {{W{1'b0}}, INPUTA};
      end
    end else begin
      case (op_r)
        OP_SHL: if (!n_zero_r) a_r <= shl_nxt;
        OP_SHR: if (!n_zero_r) a_r <= shr_nxt;
        OP_MUL: begin
          prod_r  <= mul_nxt;
          mcand_r <= {mcand_r[2*W-2:0], 1'b0};
          b_r     <= {1'b0, b_r[W-1:1]};
        end
        default: ;
      endcase
    end
  end

  // ---- sequencer and architectural result registers ----
  // Results are written only on the completing edge, so an aborted
  // operation never exposes a partial value.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= IDLE;
      cnt            <= '0;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
      OUT            <= '0;
      FLAG_OUT       <= 1'b0;
      OVERFLOW_OUT   <= 1'b0;
      FLAG_BRANCH_EN <= 1'b0;
    end else begin
      DONE           <= 1'b0;
      FLAG_BRANCH_EN <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= RUN;
            BUSY  <= 1'b1;
            cnt   <= load_count(OP, shift_count(INPUTB));
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (last_run) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            case (op_r)
              OP_ADD: {OVERFLOW_OUT, OUT} <= sum_w;
              OP_SUB: begin
                OUT          <= diff_w[W-1:0];
                OVERFLOW_OUT <= diff_w[W];
              end
              OP_CEQ: begin
                FLAG_OUT     <= (a_r == b_r);
                OUT          <= '0;
                OVERFLOW_OUT <= 1'b0;
              end
              OP_CLT: begin
                FLAG_OUT     <= (a_r < b_r);
                OUT          <= '0;
                OVERFLOW_OUT <= 1'b0;
              end
              OP_SHL: begin
                if (n_zero_r) begin
                  OUT          <= a_r;
                  OVERFLOW_OUT <= 1'b0;
                end else begin
                  OUT          <= shl_nxt;
                  OVERFLOW_OUT <= a_r[W-1];
                end
              end
              OP_SHR: begin
                if (n_zero_r) begin
                  OUT          <= a_r;
                  OVERFLOW_OUT <= 1'b0;
                end else begin
                  OUT          <= shr_nxt;
                  OVERFLOW_OUT <= a_r[0];
                end
              end
              OP_MUL: begin
                OUT          <= mul_nxt[W-1:0];
                OVERFLOW_OUT <= |mul_nxt[2*W-1:W];
              end
              OP_BR: begin
                FLAG_BRANCH_EN <= (FLAG_OUT == b_r[0]);
                OUT            <= '0;
              end
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// Directed testbench for mc_alu at W=8. Expected values are hand-computed
// constants. Cycle counts treat the cycle in which START is sampled as cycle 0.
module tb_mc_alu;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, CEQ = 3'b010, CLT = 3'b011,
                         SHL = 3'b100, SHR = 3'b101, MUL = 3'b110, BR  = 3'b111;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic [2:0] OP;
  logic [7:0] INPUTA, INPUTB;
  logic       BUSY, DONE, FLAG_OUT, OVERFLOW_OUT, FLAG_BRANCH_EN;
  logic [7:0] OUT;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int busy_n;
  logic hold_bad;
  logic seen_done;

  always #5 CLK = ~CLK;

  mc_alu #(.W(8)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OP(OP),
    .INPUTA(INPUTA), .INPUTB(INPUTB), .BUSY(BUSY), .DONE(DONE), .OUT(OUT),
    .FLAG_OUT(FLAG_OUT), .OVERFLOW_OUT(OVERFLOW_OUT),
    .FLAG_BRANCH_EN(FLAG_BRANCH_EN)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue one operation and wait (bounded) for DONE. Returns in the DONE
  // cycle, so a following run_op issues back-to-back. With noise set, START
  // is pulsed and operands are scrambled during RUN, and OUT is watched for
  // any change before completion.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input bit noise);
    logic [7:0] held;
    held     = OUT;
    hold_bad = 1'b0;
    START = 1'b1; OP = op; INPUTA = a; INPUTB = b;
    tick();
    START  = 1'b0;
    cyc    = 1;
    busy_n = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      busy_n += int'(BUSY);
      if (OUT !== held) hold_bad = 1'b1;
      if (noise && cyc < 6) begin
        START  = cyc[0];
        OP     = ADD;
        INPUTA = ~a;
        INPUTB = 8'(cyc);
      end else begin
        START = 1'b0;
      end
      tick();
      cyc++;
      if (DONE) begin
        seen_done = 1'b1;
        break;
      end
    end
    START = 1'b0;
    check("done_seen", seen_done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic dn;
    RESET = 1'b1; START = 1'b0; OP = ADD; INPUTA = '0; INPUTB = '0;
    tick(); tick();
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_out", OUT, 0);
    check("rst_flag", FLAG_OUT, 0);
    check("rst_ovf", OVERFLOW_OUT, 0);
    check("rst_bre", FLAG_BRANCH_EN, 0);
    RESET = 1'b0;
    tick();

    // 0x00 - 0x01 - 0 -> 0xFF with borrow; leaves OVERFLOW=1 for the ADD
    run_op(SUB, 8'h00, 8'h01, 0);
    check("sub0_out", OUT, 8'hFF);
    check("sub0_ovf", OVERFLOW_OUT, 1);
    check("sub0_cyc", cyc, 2);

    // 0xFF + 0x00 + 1 = 0x100
    run_op(ADD, 8'hFF, 8'h00, 0);
    check("add_out", OUT, 8'h00);
    check("add_ovf", OVERFLOW_OUT, 1);
    check("add_cyc", cyc, 2);
    check("add_flag", FLAG_OUT, 0);
    tick();
    check("done_pulse_width", DONE, 0);

    run_op(CEQ, 8'h05, 8'h07, 0);
    check("ceq57_flag", FLAG_OUT, 0);
    check("ceq57_ovf", OVERFLOW_OUT, 0);

    // 5 - 7 - 0 = -2 -> 0xFE, borrow
    run_op(SUB, 8'h05, 8'h07, 0);
    check("sub_out", OUT, 8'hFE);
    check("sub_ovf", OVERFLOW_OUT, 1);
    check("sub_flag", FLAG_OUT, 0);

    run_op(CLT, 8'h05, 8'h07, 0);
    check("clt_flag", FLAG_OUT, 1);
    check("clt_out", OUT, 0);
    check("clt_ovf", OVERFLOW_OUT, 0);

    run_op(CEQ, 8'h3C, 8'h3D, 0);
    check("ceq_ne_flag", FLAG_OUT, 0);
    run_op(CEQ, 8'h3C, 8'h3C, 0);
    check("ceq_eq_flag", FLAG_OUT, 1);

    run_op(BR, 8'h00, 8'h01, 0);
    check("br1_done", DONE, 1);
    check("br1_bre", FLAG_BRANCH_EN, 1);
    check("br1_out", OUT, 0);
    check("br1_flag", FLAG_OUT, 1);
    check("br1_ovf", OVERFLOW_OUT, 0);
    tick();
    check("br1_bre_pulse", FLAG_BRANCH_EN, 0);

    run_op(BR, 8'h00, 8'h00, 0);
    check("br0_bre", FLAG_BRANCH_EN, 0);
    check("br0_flag", FLAG_OUT, 1);

    // 0x81 << 3 = 0x08, bits shifted out 1,0,0
    run_op(SHL, 8'h81, 8'h03, 0);
    check("shl_out", OUT, 8'h08);
    check("shl_ovf", OVERFLOW_OUT, 0);
    check("shl_busy", busy_n, 3);
    check("shl_cyc", cyc, 4);
    check("shl_flag", FLAG_OUT, 1);

    // count 9 mod 8 = 1
    run_op(SHR, 8'h81, 8'h09, 0);
    check("shr_out", OUT, 8'h40);
    check("shr_ovf", OVERFLOW_OUT, 1);
    check("shr_cyc", cyc, 2);

    // count 8 mod 8 = 0: pass A through
    run_op(SHL, 8'h5A, 8'h08, 0);
    check("shl0_out", OUT, 8'h5A);
    check("shl0_ovf", OVERFLOW_OUT, 0);
    check("shl0_cyc", cyc, 2);

    // 0x10 * 0x11 = 0x110 with START pulses and operand noise during RUN
    run_op(MUL, 8'h10, 8'h11, 1);
    check("mul_out", OUT, 8'h10);
    check("mul_ovf", OVERFLOW_OUT, 1);
    check("mul_cyc", cyc, 9);
    check("mul_flag", FLAG_OUT, 1);
    check("mul_out_held", hold_bad, 0);
    tick();
    check("mul_no_requeue", BUSY, 0);

    // Abort a MUL with RESET in its 4th RUN cycle
    START = 1'b1; OP = MUL; INPUTA = 8'h0F; INPUTB = 8'h0F;
    tick();
    START = 1'b0;
    tick(); tick(); tick();
    check("abort_busy_before", BUSY, 1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("abort_busy", BUSY, 0);
    check("abort_done", DONE, 0);
    check("abort_out", OUT, 0);
    check("abort_flag", FLAG_OUT, 0);
    check("abort_ovf", OVERFLOW_OUT, 0);
    check("abort_bre", FLAG_BRANCH_EN, 0);
    dn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      dn |= DONE | BUSY;
    end
    check("abort_no_done", dn, 0);

    // RESET wins over a simultaneous START
    RESET = 1'b1; START = 1'b1; OP = ADD; INPUTA = 8'h01; INPUTB = 8'h01;
    tick();
    check("rst_prio_busy", BUSY, 0);
    RESET = 1'b0; START = 1'b0;
    tick();
    check("rst_prio_idle", BUSY, 0);
    check("rst_prio_done", DONE, 0);

    // Back-to-back: second ADD issued in the DONE cycle of the first
    run_op(ADD, 8'h30, 8'h40, 0);
    check("b2b1_out", OUT, 8'h70);
    check("b2b1_ovf", OVERFLOW_OUT, 0);
    run_op(ADD, 8'hC0, 8'h50, 0);
    check("b2b2_cyc", cyc, 2);
    check("b2b2_out", OUT, 8'h10);
    check("b2b2_ovf", OVERFLOW_OUT, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
